mem_responder: RTL
==================

# mem_responder

Memory-side responder for the processor memory bus: receives MEM_READ/MEM_WRITE/MEM_ADDR requests from the control unit, services them from an on-chip word array after a programmable number of wait states, and drives or samples the bidirectional MEM_DATA bus. It sits opposite the control unit on the memory interface and replaces the zero-latency behavioural memory with a sequential, handshaked responder. It adds MEM_READY/MEM_ERR so bus timing is explicit and checkable.

## Interface
- DATA_WIDTH, 32, word width; equals `DATA_INDEX_LIMIT+1
- ADDR_WIDTH, 26, bus address width; equals `ADDRESS_INDEX_LIMIT+1
- DEPTH_LOG2, 10, log2 of implemented words (1024)
- WAIT_STATES, 1, extra cycles before response; legal 0..15
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- MEM_ADDR  in  ADDR_WIDTH  word address
- MEM_READ  in  1  read request
- MEM_WRITE  in  1  write request
- MEM_DATA  inout  DATA_WIDTH  write data in / read data out; Z when not driving
- MEM_READY  out  1  request complete, held while request held
- MEM_ERR  out  1  address >= 2**DEPTH_LOG2; valid only with MEM_READY

## Operation
- Request decode: {MEM_READ,MEM_WRITE} = 10 read, 01 write; 00 and 11 are no-op (hold).
- FSM states IDLE, WAIT, RESP.
- IDLE: on rising edge with valid request, capture op, address, range flag, and (write) MEM_DATA; go WAIT with counter=WAIT_STATES, or RESP directly if WAIT_STATES=0.
- WAIT: counter decrements each edge; on edge with counter==1 go RESP. If request decode changes from captured op (dropped, swapped, or 11) -> IDLE, abort, no write commit, no READY.
- Write commit: on the edge entering RESP, array[addr] <= captured data, only if in range. Out-of-range writes discarded.
- RESP: MEM_READY=1, MEM_ERR=range flag. Read: MEM_DATA driven with array[captured addr] (0 if out of range) while MEM_READ=1 and MEM_WRITE=0. Stays in RESP while captured op held; on edge where request no longer matches -> IDLE.
- Address changes during WAIT/RESP ignored; captured address used throughout.
- Memory array not cleared by RST; contents X until written.

## Timing
- Reset values: state IDLE, counter 0, MEM_READY 0, MEM_ERR 0, MEM_DATA Z, captured regs 0.
- RST asserted mid-operation: immediate return to IDLE, outputs to reset values, pending write not committed; a write already committed stays.
- Latency: request sampled at edge t0 -> MEM_READY high after edge t0+max(WAIT_STATES,1)... precisely: after t0 when WAIT_STATES=0, after t0+WAIT_STATES otherwise.
- MEM_READY/MEM_ERR are registered (state-derived); MEM_DATA drive enable combinational from state and MEM_READ/MEM_WRITE, so bus releases in the same cycle MEM_READ drops.
- Back-to-back: RESP->IDLE costs one edge; new request sampled no earlier than the edge after return to IDLE (minimum one idle cycle between transactions).
- Write data sampled only at t0; later MEM_DATA changes ignored.

## Configuration
- MEM_RESP_TRACE_EN defined: on every completed transaction (entry to RESP) print one line: "@ <time>ns MEM RD|WR [0X<addr>] = 0X<data>" plus " ERR" when out of range; aborted requests print "MEM ABORT".
- Undefined: no simulation output; RTL behaviour identical.

## Structure
- Shared definitions in prj_definition.v: `DATA_INDEX_LIMIT, `ADDRESS_INDEX_LIMIT, memory FSM encodings `MEM_IDLE/`MEM_WAIT/`MEM_RESP, request codes for 10/01.
- One sub-module: mem_array (DEPTH_LOG2-addressed, synchronous write with enable, combinational read).
- FSM, counter, capture registers, range check, tri-state driver in mem_responder.

## Test plan
- Reset mid-WAIT: write 0X0000_00AA to addr 5, assert RST before READY -> READY 0, MEM_DATA Z; subsequent read of 5 returns prior value (not 0XAA).
- WAIT_STATES=2: write 0XDEADBEEF to addr 0X10 at t0 -> READY rises after t0+2; read 0X10 -> MEM_DATA=0XDEADBEEF while MEM_READ held, Z the cycle MEM_READ drops.
- WAIT_STATES=0: read addr 3 after writing 0X12345678 -> READY after one edge; back-to-back request held through return edge sampled one cycle later, not earlier.
- Abort: MEM_WRITE dropped during WAIT with data 0X55 to addr 7 -> no READY, addr 7 unchanged.
- Out of range: read addr 0X400 with DEPTH_LOG2=10 -> READY=1, MEM_ERR=1, MEM_DATA=0; write 0X400 -> MEM_ERR=1, addr 0 unchanged.
- No-op codes: {MEM_READ,MEM_WRITE}=11 and 00 for 10 cycles -> state IDLE, READY 0, MEM_DATA Z throughout.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared widths, FSM encodings and request decode for mem_responder
package mem_responder_pkg;

  localparam int DATA_INDEX_LIMIT    = 31;
  localparam int ADDRESS_INDEX_LIMIT = 25;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  // Encodings equal {MEM_READ, MEM_WRITE}; 00 and 11 both collapse to REQ_NONE
  typedef enum logic [1:0] {
    REQ_NONE  = 2'b00,
    REQ_WRITE = 2'b01,
    REQ_READ  = 2'b10
  } mem_req_t;

  function automatic mem_req_t decode_req(input logic rd, input logic wr);
    case ({rd, wr})
      2'b10:   return REQ_READ;
      2'b01:   return REQ_WRITE;
      default: return REQ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word array, synchronous write with enable, combinational read
module mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with READY/ERR and tri-state data bus
// Optional transaction trace enabled by defining MEM_RESP_TRACE_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_INDEX_LIMIT + 1,
  parameter int ADDR_WIDTH  = ADDRESS_INDEX_LIMIT + 1,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic                  MEM_READ,
  input  logic                  MEM_WRITE,
  inout  wire  [DATA_WIDTH-1:0] MEM_DATA,
  output logic                  MEM_READY,
  output logic                  MEM_ERR
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  mem_state_t            state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  mem_req_t              req, cap_op;
  logic [DEPTH_LOG2-1:0] cap_addr;
  logic                  cap_oor;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  capture;
  logic                  oor_in;
  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  drive;

  assign req    = decode_req(MEM_READ, MEM_WRITE);
  assign oor_in = |MEM_ADDR[ADDR_WIDTH-1:DEPTH_LOG2];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= MEM_IDLE;
      cnt      <= '0;
      cap_op   <= REQ_NONE;
      cap_addr <= '0;
      cap_oor  <= 1'b0;
      cap_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        cap_op   <= req;
        cap_addr <= MEM_ADDR[DEPTH_LOG2-1:0];
        cap_oor  <= oor_in;
        cap_data <= MEM_DATA;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    we        = 1'b0;
    waddr     = cap_addr;
    wdata     = cap_data;
    case (state)
      MEM_IDLE: begin
        if (req != REQ_NONE) begin
          capture = 1'b1;
          if (WS == 4'd0) begin
            // Zero wait states commit on the capture edge, so bypass the capture registers
            state_nxt = MEM_RESP;
            we        = (req == REQ_WRITE) && !oor_in;
            waddr     = MEM_ADDR[DEPTH_LOG2-1:0];
            wdata     = MEM_DATA;
          end else begin
            state_nxt = MEM_WAIT;
            cnt_nxt   = WS;
          end
        end
      end
      MEM_WAIT: begin
        if (req != cap_op) begin
          state_nxt = MEM_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 4'd1) begin
          state_nxt = MEM_RESP;
          cnt_nxt   = '0;
          we        = (cap_op == REQ_WRITE) && !cap_oor;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      MEM_RESP: begin
        if (req != cap_op) state_nxt = MEM_IDLE;
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (CLK),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(cap_addr),
    .rdata(rdata)
  );

  assign MEM_READY = (state == MEM_RESP);
  assign MEM_ERR   = (state == MEM_RESP) && cap_oor;

  // Enable follows the live request lines so the bus is released in the cycle MEM_READ drops
  assign drive    = (state == MEM_RESP) && (cap_op == REQ_READ) && MEM_READ && !MEM_WRITE;
  assign MEM_DATA = drive ? (cap_oor ? '0 : rdata) : 'z;

`ifdef MEM_RESP_TRACE_EN
  logic [ADDR_WIDTH-1:0] trace_addr;
  logic                  trace_prev_resp;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trace_addr      <= '0;
      trace_prev_resp <= 1'b0;
    end else begin
      trace_prev_resp <= (state == MEM_RESP);
      if (capture) trace_addr <= MEM_ADDR;
    end
  end

  always @(posedge CLK) begin
    if (!RST && state == MEM_RESP && !trace_prev_resp)
      $display("@ %0tns MEM %s [0X%h] = 0X%h%s", $time,
               (cap_op == REQ_READ) ? "RD" : "WR", trace_addr,
               (cap_op == REQ_READ) ? (cap_oor ? '0 : rdata) : cap_data,
               cap_oor ? " ERR" : "");
    if (!RST && state == MEM_WAIT && req != cap_op)
      $display("@ %0tns MEM ABORT", $time);
  end
`else
`endif

endmodule
